// File: rtl/logic_reduce_stream.sv
// Streaming bitwise reducer: folds a packet of WIDTH-bit beats with OR/AND/XOR into one result.
// Optional outCount port (beats in packet) enabled by defining LOGIC_REDUCE_COUNT_EN.
module logic_reduce_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  input  logic             inLast,
  input  logic [1:0]       opSel,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
`ifdef LOGIC_REDUCE_COUNT_EN
  output logic [CNT_W-1:0] outCount,
`endif
  output logic             outTrunc
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               trunc_q, trunc_d;
  logic               in_fire;
  logic [WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]   count_inc;

  // Reserved encoding 2'b11 folds as OR.
  function automatic logic [WIDTH-1:0] reduce_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign inReady   = (state_q != StDone);
  assign outValid  = (state_q == StDone);
  assign outData   = data_q;
  assign outTrunc  = trunc_q;
  assign in_fire   = inValid && inReady;
  assign acc_next  = reduce_op(op_q, acc_q, inData);
  assign count_inc = count_q + CNT_W'(1);

`ifdef LOGIC_REDUCE_COUNT_EN
  assign outCount = count_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    trunc_d = trunc_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          acc_d   = inData;
          op_d    = opSel;
          count_d = CNT_W'(1);
          if (inLast || (MAX_BEATS == 1)) begin
            state_d = StDone;
            data_d  = inData;
            trunc_d = !inLast;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (in_fire) begin
          acc_d   = acc_next;
          count_d = count_inc;
          if (inLast) begin
            state_d = StDone;
            data_d  = acc_next;
          end else if (count_inc == CNT_W'(MAX_BEATS)) begin
            state_d = StDone;
            data_d  = acc_next;
            trunc_d = 1'b1;
          end
        end
      end
      StDone: begin
        // Result and its flags stay frozen until the consumer takes them.
        if (outReady) begin
          state_d = StIdle;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      data_q  <= '0;
      op_q    <= 2'b00;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_logic_reduce_stream.sv
// Self-checking bench for logic_reduce_stream: directed vector table, hand-written corner
// sequences, and randomized traffic against a packet-level reference model.
module tb_logic_reduce_stream;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk;
  logic          rst_n;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inData;
  logic          inLast;
  logic [1:0]    opSel;
  logic          outValid;
  logic          outReady;
  logic [W-1:0]  outData;
  logic          outTrunc;
  logic [CW-1:0] outCount;

  logic_reduce_stream #(
    .WIDTH    (W),
    .MAX_BEATS(MB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inValid (inValid),
    .inReady (inReady),
    .inData  (inData),
    .inLast  (inLast),
    .opSel   (opSel),
    .outValid(outValid),
    .outReady(outReady),
    .outData (outData),
`ifdef LOGIC_REDUCE_COUNT_EN
    .outCount(outCount),
`endif
    .outTrunc(outTrunc)
  );

`ifndef LOGIC_REDUCE_COUNT_EN
  assign outCount = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests;
  int unsigned fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string name, input int exp);
`ifdef LOGIC_REDUCE_COUNT_EN
    check(name, 32'(outCount), 32'(exp));
`endif
  endtask

  typedef struct {
    string           name;
    int              n;
    logic [3:0][1:0] ops;
    logic [3:0][7:0] words;
    logic            last;
    logic [7:0]      exp_data;
    logic            exp_trunc;
  } vec_t;

  vec_t vecs[5];

  // Consecutive beats with outReady=1; result must appear exactly one cycle after the last beat.
  task automatic apply_vec(input vec_t v);
    outReady = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      inValid = 1'b1;
      inData  = v.words[i];
      opSel   = v.ops[i];
      inLast  = v.last && (i == v.n - 1);
      check({v.name, ".in_ready"}, 32'(inReady), 32'd1);
      step();
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    check({v.name, ".out_valid"}, 32'(outValid), 32'd1);
    check({v.name, ".out_data"}, 32'(outData), 32'(v.exp_data));
    check({v.name, ".out_trunc"}, 32'(outTrunc), 32'(v.exp_trunc));
    check_count({v.name, ".out_count"}, v.n);
    step();
    check({v.name, ".out_valid_drop"}, 32'(outValid), 32'd0);
  endtask

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    if (op == 2'b01) return a & b;
    if (op == 2'b10) return a ^ b;
    return a | b;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       trunc;
    int         cnt;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] cur_q[$];
  logic [1:0] cur_op;
  res_t       r;
  logic [7:0] fold;
  logic       in_acc;
  logic       out_acc;

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inLast   = 1'b0;
    opSel    = 2'b00;
    outReady = 1'b0;

    vecs[0] = '{"or3", 3, {2'b00, 2'b00, 2'b00, 2'b00}, {8'h00, 8'h80, 8'h10, 8'h01},
                1'b1, 8'h91, 1'b0};
    vecs[1] = '{"and_opchg", 3, {2'b10, 2'b10, 2'b10, 2'b01}, {8'h00, 8'h0F, 8'h3C, 8'hFF},
                1'b1, 8'h0C, 1'b0};
    vecs[2] = '{"reserved_op", 1, {2'b11, 2'b11, 2'b11, 2'b11}, {8'h00, 8'h00, 8'h00, 8'hC3},
                1'b1, 8'hC3, 1'b0};
    vecs[3] = '{"trunc4", 4, {2'b00, 2'b00, 2'b00, 2'b00}, {8'h08, 8'h04, 8'h02, 8'h01},
                1'b0, 8'h0F, 1'b1};
    vecs[4] = '{"xor2", 2, {2'b10, 2'b10, 2'b10, 2'b10}, {8'h00, 8'h00, 8'h55, 8'hAA},
                1'b1, 8'hFF, 1'b0};

    #2;
    check("rst.out_valid", 32'(outValid), 32'd0);
    check("rst.out_data", 32'(outData), 32'd0);
    check("rst.out_trunc", 32'(outTrunc), 32'd0);
    check("rst.in_ready", 32'(inReady), 32'd1);
    check_count("rst.out_count", 0);
    // Edge at t=5 happens under reset with inValid low; release between edges.
    #5 rst_n = 1'b1;
    step();

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Backpressure: result held for 5 cycles while extra beats wait.
    outReady = 1'b0;
    opSel = 2'b10; inValid = 1'b1; inData = 8'hAA; inLast = 1'b0; step();
    inData = 8'h55; inLast = 1'b1; step();
    inData = 8'h77; inLast = 1'b1; opSel = 2'b00;
    for (int c = 0; c < 5; c++) begin
      check("bp.out_valid", 32'(outValid), 32'd1);
      check("bp.out_data", 32'(outData), 32'hFF);
      check("bp.in_ready", 32'(inReady), 32'd0);
      step();
    end
    outReady = 1'b1;
    step();
    inValid = 1'b0; inLast = 1'b0;
    check("bp.idle_out_valid", 32'(outValid), 32'd0);
    check("bp.idle_in_ready", 32'(inReady), 32'd1);
    inValid = 1'b1; inData = 8'h11; inLast = 1'b1; opSel = 2'b00; step();
    inValid = 1'b0;
    check("bp.next_data", 32'(outData), 32'h11);
    step();

    // Truncation with a 5th word stalled until the result is taken.
    outReady = 1'b0; opSel = 2'b00; inLast = 1'b0; inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inData = 8'(1 << i);
      step();
    end
    inData = 8'h20; inLast = 1'b1;
    for (int c = 0; c < 2; c++) begin
      check("tr.in_ready", 32'(inReady), 32'd0);
      check("tr.out_trunc", 32'(outTrunc), 32'd1);
      check("tr.out_data", 32'(outData), 32'h0F);
      check_count("tr.out_count", 4);
      step();
    end
    outReady = 1'b1;
    step();
    check("tr.after_accept_trunc", 32'(outTrunc), 32'd0);
    step();
    inValid = 1'b0; inLast = 1'b0;
    check("tr.next_valid", 32'(outValid), 32'd1);
    check("tr.next_data", 32'(outData), 32'h20);
    check("tr.next_trunc", 32'(outTrunc), 32'd0);
    step();

    // Reset mid-packet, then reset while a result is pending.
    opSel = 2'b00; inValid = 1'b1; inData = 8'hF0; inLast = 1'b0; step();
    inData = 8'h0F; step();
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rm.out_data", 32'(outData), 32'd0);
    check("rm.out_valid", 32'(outValid), 32'd0);
    #1 rst_n = 1'b1;
    step();
    outReady = 1'b0; inValid = 1'b1; inData = 8'h33; inLast = 1'b1; step();
    inValid = 1'b0;
    check("rd.pending", 32'(outValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rd.out_valid", 32'(outValid), 32'd0);
    check("rd.out_data", 32'(outData), 32'd0);
    #1 rst_n = 1'b1;
    step();
    outReady = 1'b1; inValid = 1'b1; inData = 8'h5A; inLast = 1'b1; opSel = 2'b00; step();
    inValid = 1'b0; inLast = 1'b0;
    check("rs.out_data", 32'(outData), 32'h5A);
    step();

    // Idle gaps inside a packet.
    inValid = 1'b1; inData = 8'h01; opSel = 2'b00; step();
    inValid = 1'b0; inData = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      check("gap.out_valid", 32'(outValid), 32'd0);
      step();
    end
    inValid = 1'b1; inData = 8'h40; inLast = 1'b1; step();
    inValid = 1'b0; inLast = 1'b0;
    check("gap.out_data", 32'(outData), 32'h41);
    step();

    // Randomized traffic against the packet-level model.
    for (int c = 0; c < 3000; c++) begin
      inValid  = ($urandom_range(9) < 6);
      inData   = 8'($urandom);
      inLast   = ($urandom_range(9) < 3);
      opSel    = 2'($urandom);
      outReady = ($urandom_range(9) < 7);
      #3;
      in_acc  = inValid && inReady;
      out_acc = outValid && outReady;
      if (outValid && inReady) check("rnd.ready_while_valid", 32'd1, 32'd0);
      if (out_acc) begin
        if (exp_q.size() == 0) begin
          check("rnd.unexpected_result", 32'(outData), 32'hFFFF_FFFF);
        end else begin
          r = exp_q.pop_front();
          check("rnd.out_data", 32'(outData), 32'(r.data));
          check("rnd.out_trunc", 32'(outTrunc), 32'(r.trunc));
          check_count("rnd.out_count", r.cnt);
        end
      end
      if (in_acc) begin
        if (cur_q.size() == 0) cur_op = opSel;
        cur_q.push_back(inData);
        if (inLast || cur_q.size() == MB) begin
          fold = cur_q[0];
          for (int k = 1; k < cur_q.size(); k++) fold = ref_op(cur_op, fold, cur_q[k]);
          exp_q.push_back('{fold, !inLast, cur_q.size()});
          cur_q.delete();
        end
      end
      step();
    end
    inValid = 1'b0;
    outReady = 1'b1;
    #3;
    if (outValid) begin
      if (exp_q.size() == 0) begin
        check("rnd.drain_unexpected", 32'(outData), 32'hFFFF_FFFF);
      end else begin
        r = exp_q.pop_front();
        check("rnd.drain_data", 32'(outData), 32'(r.data));
      end
    end
    step();
    check("rnd.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
